quad_sched: RTL and testbench
=============================

# quad_sched

- Frame scheduler that shares one `quad` round core between `NREQ` message requesters.
- Runs the core's word input on a free-running frame of `FRAME_LEN` slots:
  - the first `MSG_WORDS` slots carry the owning requester's message words;
  - the remaining slots carry `PAD_WORD`;
  - `phase_advance` is asserted on the last slot.
- Collects the next message into a double buffer while the current one is emitted, so back-to-back frames need no idle gap.

## Interface

Parameters:

- `NREQ`, 2, number of requesters (≥2)
- `FRAME_LEN`, 20, slots per frame
- `MSG_WORDS`, 5, maximum message words per frame (< `FRAME_LEN`)
- `PAD_WORD`, 32'h96877869, filler word for unused slots

Ports:

- `clk`  in  1  single clock, all logic on posedge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  NREQ  per-requester word valid
- `req_ready`  out  NREQ  per-requester word accept
- `req_data`  in  NREQ×32  per-requester word, packed `[NREQ-1:0][31:0]`
- `req_last`  in  NREQ  marks final word of a message
- `Din`  out  32  word to `quad` for current slot
- `phase_advance`  out  1  high on slot `FRAME_LEN-1` only
- `frame_start`  out  1  high on slot 0 only
- `frame_valid`  out  1  current frame carries a message (held for whole frame)
- `frame_id`  out  max(1,$clog2(NREQ))  owner of current frame (held for whole frame)
- `trunc`  out  1  one-cycle pulse: message forcibly ended at `MSG_WORDS`

## Operation

- **Slot counter**
  - 0..`FRAME_LEN-1`; wraps every cycle at the top.
  - Cleared by `reset`; never stalls.
- **Emitter**
  - Reads the emit bank.
  - Slot s < stored length: `Din` = word s.
  - Otherwise: `Din` = `PAD_WORD`.
- **Collector states:**
  - **ARB**
    - Round-robin grant among requesters with `req_valid`=1.
    - Search starts at (last grant + 1); at reset, last grant = `NREQ-1`.
    - Nothing valid: stay in ARB.
    - Otherwise latch `grant` and go to COLLECT.
  - **COLLECT**
    - `req_ready[grant]`=1, all other bits 0.
    - Each `req_valid`&`req_ready` handshake writes the fill bank at index k and increments k.
    - Exit on `req_last`, or when k reaches `MSG_WORDS`; either exit goes to FULL.
    - On reaching `MSG_WORDS` without `req_last`, `trunc` pulses. The requester's remaining words form its next message.
  - **FULL**
    - `req_ready`=0.
    - Waits for the frame boundary.
- **Frame boundary** is the edge leaving slot `FRAME_LEN-1`:
  - Collector in FULL:
    - banks swap;
    - `frame_valid`=1 and `frame_id`=grant for the new frame;
    - collector returns to ARB.
  - Otherwise: idle frame, with `frame_valid`=0, `frame_id` holding its old value, and `Din`=`PAD_WORD` in all slots.
  - COLLECT in progress at the boundary is not aborted; it carries into the next frame.
- **Widths:** slot counter $clog2(`FRAME_LEN`); word index and length $clog2(`MSG_WORDS`+1).

## Timing

- All outputs are registered except `req_ready`, which is decoded from state registers only. There is no combinational path from `req_valid` to `req_ready`.
- Reset values:
  - `Din`=`PAD_WORD`
  - `phase_advance`=0, `frame_start`=0
  - `frame_valid`=0, `frame_id`=0
  - `trunc`=0, `req_ready`=0
  - collector in ARB, both banks empty
- Slot timing:
  - Cycle c = first cycle with `reset` low.
  - Outputs for slot j appear in cycle c+1+j (mod `FRAME_LEN`).
  - The first `frame_start` is at c+1; the first `phase_advance` is at c+`FRAME_LEN`.
- ARB costs 1 cycle. The earliest first word accept is c+1.
- A last word accepted at cycle t reaches FULL at t+1. It is emitted in the frame whose boundary edge comes after t+1.
- If FULL is entered on the same edge as the boundary, the message misses that frame and waits one full frame.
- `reset` asserted mid-operation: outputs take reset values on the next edge. Partial and buffered messages are discarded with no `trunc` pulse.

## Structure

- Package `quad_pkg`: `word_t` (32-bit), `PAD_WORD` default, collector state enum (ARB/COLLECT/FULL).
- One sub-module, `quad_msg_bank`: two-bank `MSG_WORDS`×32 storage with write index, stored length and swap select.
- Arbiter, FSM and slot counter stay in `quad_sched`.

## Test plan

- **Single full message.** Req0 sends 54686973, 20697320, 61207465, 73742031, 32332e0a (last on the 5th).
  - Next frame: `frame_id`=0, `frame_valid`=1.
  - Slots 0–4 carry those words; slots 5–19 carry 96877869.
  - `phase_advance` only on slot 19; `frame_start` only on slot 0.
- **Short message.** Req1 sends 2 words: slots 0–1 = data, slots 2–19 = `PAD_WORD`, `frame_id`=1.
- **Contention.** Both requesters always valid with 5-word messages: `frame_id` sequence 0,1,0,1… and no idle frames after the first.
- **Truncation.** Req0 sends 7 words, no `req_last`:
  - `trunc` pulses with the 5th accept;
  - words 6–7 become the next req0 message, emitted as 2 data slots.
- **Idle.** No requests for 100 cycles: `frame_valid`=0, `Din`=96877869 throughout, `phase_advance` every 20 cycles starting at c+20.
- **Reset mid-collection.** Reset asserted after 3 accepted words: all outputs at reset values and `req_ready`=0. After release, slot 0 appears at c+1 and the partial message is never emitted.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and defaults for the quad frame scheduler.
package quad_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PAD_WORD_DEF = 32'h96877869;

    typedef enum logic [1:0] {
        ST_ARB,
        ST_COLLECT,
        ST_FULL
    } coll_state_t;

endpackage

// File: rtl/quad_msg_bank.sv
// Double-buffered message store: one bank fills while the other is emitted.
module quad_msg_bank
    import quad_pkg::*;
#(
    parameter int MSG_WORDS = 5,
    parameter int IW        = $clog2(MSG_WORDS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  word_t         wr_data,
    input  logic          swap,
    input  logic [IW-1:0] rd_idx,
    output word_t         rd_data,
    output logic [IW-1:0] wr_idx,
    output logic [IW-1:0] emit_len
);

    localparam int AW = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;

    word_t mem [2][MSG_WORDS];
    logic  fill_sel;
    logic  emit_sel;

    assign emit_sel = ~fill_sel;
    assign rd_data  = mem[emit_sel][AW'(rd_idx)];

    // Bank select, fill index and emitted length; a swap hands the fill count over as the emit length.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_sel <= 1'b0;
            wr_idx   <= '0;
            emit_len <= '0;
        end else if (swap) begin
            fill_sel <= ~fill_sel;
            emit_len <= wr_idx;
            wr_idx   <= '0;
        end else if (wr_en) begin
            wr_idx <= wr_idx + 1'b1;
        end
    end

    // Word storage; contents need no reset because the lengths gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[fill_sel][AW'(wr_idx)] <= wr_data;
        end
    end

endmodule

// File: rtl/quad_sched.sv
// Frame scheduler sharing one quad round core between NREQ message requesters.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ARB     | round-robin pick of the next requester with a word waiting
// ST_COLLECT | accepting words from grant into the fill bank
// ST_FULL    | fill bank complete, waiting for the frame boundary to swap
module quad_sched
    import quad_pkg::*;
#(
    parameter int    NREQ      = 2,
    parameter int    FRAME_LEN = 20,
    parameter int    MSG_WORDS = 5,
    parameter word_t PAD_WORD  = PAD_WORD_DEF,
    localparam int   IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  word_t [NREQ-1:0]     req_data,
    input  logic [NREQ-1:0]      req_last,
    output word_t                Din,
    output logic                 phase_advance,
    output logic                 frame_start,
    output logic                 frame_valid,
    output logic [IDW-1:0]       frame_id,
    output logic                 trunc
);

    localparam int SW = $clog2(FRAME_LEN);
    localparam int IW = $clog2(MSG_WORDS + 1);

    coll_state_t    state;
    coll_state_t    state_nxt;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] grant_nxt;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] arb_sel;
    logic           arb_found;

    logic [SW-1:0]  slot;
    logic           frame_end;
    logic           accept;
    logic           at_cap;
    logic           wr_en;
    logic           swap;
    logic           trunc_nxt;

    logic           emit_valid;
    logic [IDW-1:0] emit_id;
    word_t          rd_data;
    logic [IW-1:0]  wr_idx;
    logic [IW-1:0]  emit_len;

    assign frame_end = (slot == SW'(FRAME_LEN - 1));
    assign accept    = (state == ST_COLLECT) && req_valid[grant];
    assign at_cap    = (wr_idx == IW'(MSG_WORDS - 1));

    quad_msg_bank #(
        .MSG_WORDS (MSG_WORDS),
        .IW        (IW)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (req_data[grant]),
        .swap     (swap),
        .rd_idx   (IW'(slot)),
        .rd_data  (rd_data),
        .wr_idx   (wr_idx),
        .emit_len (emit_len)
    );

    // Round-robin search beginning one past the previous grant.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = grant;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(grant) + i) % NREQ);
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_sel   = cand;
            end
        end
    end

    // Ready depends only on registered state, never on req_valid.
    always_comb begin
        req_ready = '0;
        if (state == ST_COLLECT) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Collector next-state, bank write/swap strobes and truncation detect.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        wr_en     = 1'b0;
        swap      = 1'b0;
        trunc_nxt = 1'b0;
        case (state)
            ST_ARB: begin
                if (arb_found) begin
                    grant_nxt = arb_sel;
                    state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (req_last[grant]) begin
                        state_nxt = ST_FULL;
                    end else if (at_cap) begin
                        state_nxt = ST_FULL;
                        trunc_nxt = 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (frame_end) begin
                    swap      = 1'b1;
                    state_nxt = ST_ARB;
                end
            end
            default: state_nxt = ST_ARB;
        endcase
    end

    // Collector state and grant registers; grant starts at NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_ARB;
            grant <= IDW'(NREQ - 1);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    // Free-running slot counter, frame ownership and registered core-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot          <= '0;
            emit_valid    <= 1'b0;
            emit_id       <= '0;
            Din           <= PAD_WORD;
            phase_advance <= 1'b0;
            frame_start   <= 1'b0;
            frame_valid   <= 1'b0;
            frame_id      <= '0;
            trunc         <= 1'b0;
        end else begin
            slot          <= frame_end ? '0 : slot + 1'b1;
            frame_start   <= (slot == '0);
            phase_advance <= frame_end;
            frame_valid   <= emit_valid;
            frame_id      <= emit_id;
            trunc         <= trunc_nxt;
            Din           <= (emit_valid && (slot < SW'(emit_len))) ? rd_data : PAD_WORD;
            if (frame_end) begin
                emit_valid <= swap;
                if (swap) begin
                    emit_id <= grant;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_sched.sv
// Scoreboard bench for quad_sched: stimulus pushes expected frames, a monitor checks each frame.
module tb_quad_sched;

    localparam logic [31:0] PAD = 32'h96877869;

    typedef struct packed {
        logic [0:0]       id;
        logic [2:0]       len;
        logic [4:0][31:0] w;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_data;
    logic [1:0]       req_last;
    logic [31:0]      Din;
    logic             phase_advance;
    logic             frame_start;
    logic             frame_valid;
    logic [0:0]       frame_id;
    logic             trunc;

    quad_sched #(
        .NREQ      (2),
        .FRAME_LEN (20),
        .MSG_WORDS (5),
        .PAD_WORD  (32'h96877869)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_last      (req_last),
        .Din           (Din),
        .phase_advance (phase_advance),
        .frame_start   (frame_start),
        .frame_valid   (frame_valid),
        .frame_id      (frame_id),
        .trunc         (trunc)
    );

    exp_t        exp_q[$];
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int acc0 = 0;
    int acc1 = 0;
    int acc0_log [64];
    bit hs0;
    bit hs1;

    int frames_checked = 0;
    int idle_frames = 0;
    int n_valid = 0;
    int idle_at [32];
    int trunc_cnt = 0;
    int trunc_cyc = -1;
    int first_fs = -1;
    int first_pa = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic send(input int r, input int n, input logic [6:0][31:0] w, input int last_idx);
        for (int i = 0; i < n; i++) begin
            logic [32:0] e;
            e = {(i == last_idx), w[i[2:0]]};
            if (r == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic push_exp(input logic [0:0] id, input int len, input logic [4:0][31:0] w);
        exp_t e;
        e.id  = id;
        e.len = 3'(len);
        e.w   = w;
        exp_q.push_back(e);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_checked < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frames_done", 32'(frames_checked), 32'(target));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_Din"}, Din, PAD);
        chk({tag, "_phase_advance"}, 32'(phase_advance), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
        chk({tag, "_frame_id"}, 32'(frame_id), 32'd0);
        chk({tag, "_trunc"}, 32'(trunc), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Requester models: present queue heads, retire them on handshake.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        hs0 = 1'b0;
        hs1 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hs0 && q0.size() > 0) begin
                void'(q0.pop_front());
                acc0_log[acc0] = cyc - 1;
                acc0++;
            end
            if (hs1 && q1.size() > 0) begin
                void'(q1.pop_front());
                acc1++;
            end
            req_valid[0] = (q0.size() > 0);
            req_data[0]  = (q0.size() > 0) ? q0[0][31:0] : 32'd0;
            req_last[0]  = (q0.size() > 0) ? q0[0][32] : 1'b0;
            req_valid[1] = (q1.size() > 0);
            req_data[1]  = (q1.size() > 0) ? q1[0][31:0] : 32'd0;
            req_last[1]  = (q1.size() > 0) ? q1[0][32] : 1'b0;
            #1;
            hs0 = req_valid[0] && req_ready[0];
            hs1 = req_valid[1] && req_ready[1];
        end
    end

    // Frame monitor: tracks slot position and checks every slot against the scoreboard.
    initial begin
        bit          in_sync;
        bit          cur_fv;
        bit          cur_has;
        logic [0:0]  cur_id;
        logic [0:0]  prev_id;
        int          slot_e;
        exp_t        cur;
        logic [31:0] w;
        in_sync = 0;
        cur_fv  = 0;
        cur_has = 0;
        cur_id  = '0;
        prev_id = '0;
        slot_e  = 0;
        cur     = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_sync  = 0;
                cur_fv   = 0;
                cur_has  = 0;
                prev_id  = '0;
                first_fs = -1;
                first_pa = -1;
            end else begin
                if (trunc) begin
                    trunc_cnt++;
                    trunc_cyc = cyc;
                end
                if (phase_advance && first_pa < 0) first_pa = cyc;
                if (!in_sync) begin
                    if (frame_start) begin
                        in_sync  = 1;
                        slot_e   = 0;
                        first_fs = cyc;
                    end
                end else begin
                    slot_e = (slot_e + 1) % 20;
                end
                if (in_sync) begin
                    chk("frame_start", 32'(frame_start), 32'(slot_e == 0));
                    chk("phase_advance", 32'(phase_advance), 32'(slot_e == 19));
                    if (slot_e == 0) begin
                        cur_fv  = frame_valid;
                        cur_id  = frame_id;
                        cur_has = 0;
                        if (frame_valid) begin
                            idle_at[n_valid % 32] = idle_frames;
                            n_valid++;
                            if (exp_q.size() == 0) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL unexpected_frame: actual frame_valid=1 id=%0d required no frame (cycle %0d)", frame_id, cyc);
                            end else begin
                                cur     = exp_q.pop_front();
                                cur_has = 1;
                                chk("frame_id", 32'(frame_id), 32'(cur.id));
                            end
                        end else begin
                            idle_frames++;
                            chk("idle_frame_id_hold", 32'(frame_id), 32'(prev_id));
                        end
                    end else begin
                        chk("frame_valid_hold", 32'(frame_valid), 32'(cur_fv));
                        chk("frame_id_hold", 32'(frame_id), 32'(cur_id));
                    end
                    if (cur_fv && cur_has && slot_e < int'(cur.len)) w = cur.w[slot_e[2:0]];
                    else                                               w = PAD;
                    chk("Din", Din, w);
                    if (slot_e == 19 && cur_fv) begin
                        frames_checked++;
                        prev_id = cur_id;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual simulation still running required finished (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0][31:0] t1;
        logic [6:0][31:0] t2;
        logic [6:0][31:0] t4;
        logic [6:0][31:0] t5;
        logic [6:0][31:0] t6;
        logic [6:0][31:0] m0;
        logic [6:0][31:0] m1;
        logic [4:0][31:0] e2;
        int c;
        int b0;
        int b1;
        int tb;
        int n;

        t1 = {32'h0, 32'h0, 32'h32332e0a, 32'h73742031, 32'h61207465, 32'h20697320, 32'h54686973};
        t2 = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h51525354, 32'h41424344};
        t4 = {32'hC0000007, 32'hC0000006, 32'hC0000005, 32'hC0000004,
              32'hC0000003, 32'hC0000002, 32'hC0000001};
        t5 = {32'h0, 32'h0, 32'hD0000005, 32'hD0000004, 32'hD0000003, 32'hD0000002, 32'hD0000001};
        t6 = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hE0E0E0E0};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");

        // Idle after reset: pad words only, phase_advance every 20 cycles from c+20.
        c = cyc;
        reset = 1'b0;
        repeat (100) begin
            @(negedge clk);
            chk("idle_phase_advance", 32'(phase_advance), 32'((cyc - c) % 20 == 0));
            chk("idle_frame_valid", 32'(frame_valid), 32'd0);
            chk("idle_Din", Din, PAD);
        end
        chk("first_frame_start", 32'(first_fs), 32'(c + 1));
        chk("first_phase_advance", 32'(first_pa), 32'(c + 20));

        // Single full-length message from requester 0.
        send(0, 5, t1, 4);
        push_exp(1'b0, 5, t1[4:0]);
        wait_frames(1, 100);

        // Short message from requester 1.
        send(1, 2, t2, 1);
        push_exp(1'b1, 2, t2[4:0]);
        wait_frames(2, 100);
        chk("no_trunc_yet", 32'(trunc_cnt), 32'd0);

        // Contention: both requesters always valid, grants alternate starting with 0.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 7; i++) begin
                m0[i] = 32'hA0000000 | 32'(k << 8) | 32'(i);
                m1[i] = 32'hB0000000 | 32'(k << 8) | 32'(i);
            end
            send(0, 5, m0, 4);
            send(1, 5, m1, 4);
            push_exp(1'b0, 5, m0[4:0]);
            push_exp(1'b1, 5, m1[4:0]);
        end
        wait_frames(10, 400);
        chk("contention_no_idle", 32'(idle_at[9]), 32'(idle_at[2]));

        // Truncation: 7 words, req_last only on the 7th.
        b0 = acc0;
        tb = trunc_cnt;
        send(0, 7, t4, 6);
        push_exp(1'b0, 5, t4[4:0]);
        e2 = '0;
        e2[0] = t4[5];
        e2[1] = t4[6];
        push_exp(1'b0, 2, e2);
        wait_frames(12, 200);
        chk("trunc_count", 32'(trunc_cnt), 32'(tb + 1));
        chk("trunc_cycle", 32'(trunc_cyc), 32'(acc0_log[b0 + 4] + 1));

        // Reset after three accepted words of a requester 1 message.
        b1 = acc1;
        send(1, 5, t5, 4);
        n = 0;
        while (acc1 < b1 + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accepts_before_reset", 32'(acc1), 32'(b1 + 3));
        reset = 1'b1;
        q1.delete();
        @(negedge clk);
        chk_reset_outputs("midreset");
        @(negedge clk);
        c = cyc;
        reset = 1'b0;
        repeat (80) @(negedge clk);
        chk("reset_first_frame_start", 32'(first_fs), 32'(c + 1));
        chk("partial_not_emitted", 32'(frames_checked), 32'd12);
        chk("accepts_after_reset", 32'(acc1), 32'(b1 + 3));

        // Recovery: one-word message from requester 0.
        send(0, 1, t6, 0);
        push_exp(1'b0, 1, t6[4:0]);
        wait_frames(13, 100);
        chk("trunc_total", 32'(trunc_cnt), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
